// File: rtl/sha256_pad.sv
// SHA-256 message padder.
// Accepts a big-endian 32-bit word stream. Produces padded 512-bit blocks as
// eight 64-bit schedule beats per block, in order. Beat k is {W[2k+1], W[2k]}.
// The 0x80 terminator, the zero fill and the 64-bit bit-length are inserted
// after the last message word. An extra block is added when the length field
// does not fit in the current block.
module sha256_pad (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  input  logic [2:0]  in_bytes_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_data_o,
  output logic        out_first_o,
  output logic        out_final_o
);

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_PAD  = 2'd1,
    S_LEN  = 2'd2
  } state_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  state_t      r_state;
  logic [3:0]  r_widx;
  logic [60:0] r_bytes;
  logic [31:0] r_held;
  logic        r_pad80;       // a full last word was taken; 0x80000000 still owed
  logic        r_out_valid;
  logic [63:0] r_out_data;
  logic        r_out_first;
  logic        r_out_final;

  state_t      w_state_nxt;
  logic [3:0]  w_widx_nxt;
  logic [60:0] w_bytes_nxt;
  logic [31:0] w_held_nxt;
  logic        w_pad80_nxt;
  logic        w_load;
  logic [63:0] w_beat;
  logic        w_beat_final;
  logic        w_out_free;
  logic        w_take;
  logic [2:0]  w_nbytes;
  logic [31:0] w_word;
  logic [31:0] w_gen;
  logic [63:0] w_len;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_free = !r_out_valid || out_ready_i;
  assign in_ready_o = (r_state == S_DATA) && w_out_free;
  assign w_take     = in_valid_i && in_ready_o;

  // Byte counts above four mean a full word.
  assign w_nbytes = (in_bytes_i > 3'd4) ? 3'd4 : in_bytes_i;
  assign w_len    = {r_bytes, 3'b000};
  assign w_gen    = r_pad80 ? PAD_WORD : 32'h0;

  // Word placed into the block: the last word is cut to its valid bytes and
  // gets the 0x80 terminator when a byte slot is free inside it.
  always_comb begin
    w_word = in_data_i;
    if (in_last_i) begin
      case (w_nbytes)
        3'd0:    w_word = PAD_WORD;
        3'd1:    w_word = {in_data_i[31:24], 8'h80, 16'h0000};
        3'd2:    w_word = {in_data_i[31:16], 8'h80, 8'h00};
        3'd3:    w_word = {in_data_i[31:8], 8'h80};
        default: w_word = in_data_i;
      endcase
    end
  end

  // Next-state and beat formation for the data, padding and length phases.
  always_comb begin
    // NOTE: every signal gets its default first so no path leaves one
    // unassigned; otherwise synthesis infers a latch.
    w_state_nxt  = r_state;
    w_widx_nxt   = r_widx;
    w_bytes_nxt  = r_bytes;
    w_held_nxt   = r_held;
    w_pad80_nxt  = r_pad80;
    w_load       = 1'b0;
    w_beat       = 64'h0;
    w_beat_final = 1'b0;

    case (r_state)
      S_DATA: begin
        if (w_take) begin
          w_bytes_nxt = r_bytes + (in_last_i ? 61'(w_nbytes) : 61'd4);
          w_widx_nxt  = r_widx + 4'd1;
          if (!r_widx[0]) begin
            w_held_nxt = w_word;
          end else begin
            w_load = 1'b1;
            w_beat = {w_word, r_held};
          end
          if (in_last_i) begin
            w_pad80_nxt = (w_nbytes == 3'd4);
            // Terminator already placed and length slot is next: skip padding.
            if ((w_widx_nxt == 4'd14) && (w_nbytes != 3'd4)) begin
              w_state_nxt = S_LEN;
            end else begin
              w_state_nxt = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        if (w_out_free) begin
          w_load      = 1'b1;
          w_pad80_nxt = 1'b0;
          w_held_nxt  = 32'h0;
          if (r_widx[0]) begin
            w_beat     = {w_gen, r_held};
            w_widx_nxt = r_widx + 4'd1;
          end else begin
            w_beat     = {32'h0, w_gen};
            w_widx_nxt = r_widx + 4'd2;
          end
          if (w_widx_nxt == 4'd14) begin
            w_state_nxt = S_LEN;
          end
        end
      end

      S_LEN: begin
        if (w_out_free) begin
          w_load       = 1'b1;
          w_beat       = {w_len[31:0], w_len[63:32]};
          w_beat_final = 1'b1;
          w_state_nxt  = S_DATA;
          w_widx_nxt   = 4'd0;
          w_bytes_nxt  = 61'd0;
          w_held_nxt   = 32'h0;
          w_pad80_nxt  = 1'b0;
        end
      end

      default: w_state_nxt = S_DATA;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state uses non-blocking assignments so every register samples the
    // values from before this edge, independent of statement order.
    if (!rst_ni) begin
      r_state <= S_DATA;
      r_widx  <= 4'd0;
      r_bytes <= 61'd0;
      r_held  <= 32'h0;
      r_pad80 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_widx  <= w_widx_nxt;
      r_bytes <= w_bytes_nxt;
      r_held  <= w_held_nxt;
      r_pad80 <= w_pad80_nxt;
    end
  end

  // Output beat register. It holds its contents while stalled.
  always_ff @(posedge clk_i) begin
    // NOTE: the data path is reset as well as valid. A reset in mid-message
    // must leave no trace of the aborted beat on out_data_o.
    if (!rst_ni) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 64'h0;
      r_out_first <= 1'b0;
      r_out_final <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_beat;
      r_out_first <= (r_widx[3:1] == 3'd0);
      r_out_final <= w_beat_final;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_first_o = r_out_first;
  assign out_final_o = r_out_final;

endmodule
